// File: rtl/memory_reader.sv
// Sequential read-back initiator: walks addr through 0..NUM_BYTES-1, streams each
// byte out on a valid/ready port and accumulates a mod-256 checksum.
module memory_reader #(
  parameter int NUM_BYTES = 4,
  parameter int ADDR_W    = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] addr_o,
  input  logic [7:0]        mem_data_i,
  output logic [7:0]        out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [7:0]        checksum_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SEND   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BYTES - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        out_data_q;
  logic [7:0]        checksum_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              busy_q;
  logic              done_q;

  logic [7:0]        checksum_d;
  logic              is_last_d;

  // addr_q doubles as the byte index; mem_data_i is already settled for it in SETTLE
  assign checksum_d = checksum_q + mem_data_i;
  assign is_last_d  = (addr_q == LAST_IDX);

  // Read-back sequencer with all outputs held in registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      out_data_q  <= 8'h00;
      checksum_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q    <= SETTLE;
            addr_q     <= '0;
            checksum_q <= 8'h00;
            busy_q     <= 1'b1;
          end
        end
        SETTLE: begin
          state_q     <= SEND;
          out_data_q  <= mem_data_i;
          checksum_q  <= checksum_d;
          out_valid_q <= 1'b1;
          out_last_q  <= is_last_d;
        end
        SEND: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (out_last_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              addr_q  <= addr_q + 1'b1;
              state_q <= SETTLE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          addr_q  <= '0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign addr_o      = addr_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign checksum_o  = checksum_q;

endmodule
